alu_mc: RTL and testbench

ALU_MC -- requirements
Module: alu_mc

---
 rtl/alu_mc_if.sv | 28 ++
 rtl/alu_mc.sv | 186 ++++++++++++++++++
 tb/tb_alu_mc.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/alu_mc_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_mc_if
// Purpose  : Control/status bundle between the multi-cycle ALU and its host.
// Revision : 1.0
// ============================================================================
interface alu_mc_if #(
    parameter int WIDTH = 16
) ();
    logic             ialu;
    logic [3:0]       op;
    logic [WIDTH-1:0] data_a;
    logic             ealu;
    logic             busy;
    logic             done;
    logic [3:0]       flags;

    modport master (
        output ialu, op, data_a, ealu,
        input  busy, done, flags
    );

    modport slave (
        input  ialu, op, data_a, ealu,
        output busy, done, flags
    );
endinterface
`default_nettype wire

// File: rtl/alu_mc.sv
`default_nettype none
// ============================================================================
// Module   : alu_mc
// Purpose  : Accumulator ALU on a shared tri-state bus; MUL runs as a
//            WIDTH-cycle shift-add, all other ops complete in one cycle.
// Revision : 1.0
// ============================================================================
module alu_mc #(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    alu_mc_if.slave               bus,
    inout  wire logic [WIDTH-1:0] data
);

    localparam logic [3:0] c_op_shl = 4'd0;
    localparam logic [3:0] c_op_add = 4'd1;
    localparam logic [3:0] c_op_sub = 4'd2;
    localparam logic [3:0] c_op_xor = 4'd3;
    localparam logic [3:0] c_op_or  = 4'd4;
    localparam logic [3:0] c_op_and = 4'd5;
    localparam logic [3:0] c_op_shr = 4'd6;
    localparam logic [3:0] c_op_not = 4'd7;
    localparam logic [3:0] c_op_mul = 4'd8;
    localparam logic [3:0] c_op_sar = 4'd9;

    localparam logic [SHW:0] c_cnt_last = (SHW+1)'(WIDTH-1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [WIDTH-1:0]     r_res;
    logic [3:0]           r_flags;
    logic                 r_busy;
    logic                 r_done;
    logic [2*WIDTH-1:0]   r_acc;
    logic [2*WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]     r_mplier;
    logic [SHW:0]         r_cnt;

    logic [WIDTH-1:0]     w_a;
    logic [WIDTH-1:0]     w_opb;
    logic [WIDTH:0]       w_sum;
    logic [WIDTH:0]       w_diff;
    logic [WIDTH:0]       w_shl;
    logic [WIDTH-1:0]     w_res;
    logic                 w_c;
    logic                 w_v;
    logic                 w_legal;
    logic [3:0]           w_flags;
    logic [2*WIDTH-1:0]   w_acc_nxt;
    logic [WIDTH-1:0]     w_prod_lo;
    logic                 w_start_mul;
    logic                 w_wr_single;
    logic                 w_mul_last;

    // With ealu high the bus carries res, so operand B loops back the accumulator.
    assign w_a   = bus.data_a;
    assign w_opb = bus.ealu ? r_res : data;
    assign data  = bus.ealu ? r_res : {WIDTH{1'bz}};

    assign bus.busy  = r_busy;
    assign bus.done  = r_done;
    assign bus.flags = r_flags;

    always_comb begin
        w_sum   = {1'b0, w_a} + {1'b0, w_opb};
        w_diff  = {1'b0, w_a} - {1'b0, w_opb};
        // Bit WIDTH holds the last bit shifted out; it is 0 for amounts above WIDTH.
        w_shl   = {1'b0, w_a} << w_opb;
        w_res   = r_res;
        w_c     = 1'b0;
        w_v     = 1'b0;
        w_legal = 1'b1;
        case (bus.op)
            c_op_shl: begin
                w_res = w_shl[WIDTH-1:0];
                w_c   = w_shl[WIDTH];
            end
            c_op_add: begin
                w_res = w_sum[WIDTH-1:0];
                w_c   = w_sum[WIDTH];
                w_v   = (w_a[WIDTH-1] == w_opb[WIDTH-1]) && (w_sum[WIDTH-1] != w_a[WIDTH-1]);
            end
            c_op_sub: begin
                w_res = w_diff[WIDTH-1:0];
                w_c   = w_diff[WIDTH];
                w_v   = (w_a[WIDTH-1] != w_opb[WIDTH-1]) && (w_diff[WIDTH-1] != w_a[WIDTH-1]);
            end
            c_op_xor: w_res = w_a ^ w_opb;
            c_op_or:  w_res = w_a | w_opb;
            c_op_and: w_res = w_a & w_opb;
            c_op_shr: w_res = w_a >> w_opb;
            c_op_not: w_res = ~w_a;
            c_op_sar: w_res = $signed(w_a) >>> w_opb;
            c_op_mul: w_legal = 1'b1;
            default:  w_legal = 1'b0;
        endcase
        w_flags = {w_v, w_c, w_res[WIDTH-1], (w_res == '0)};
    end

    assign w_acc_nxt = r_acc + (r_mplier[0] ? r_mcand : '0);
    assign w_prod_lo = w_acc_nxt[WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start_mul = 1'b0;
        w_wr_single = 1'b0;
        w_mul_last  = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (bus.ialu) begin
                    if (bus.op == c_op_mul) begin
                        w_start_mul = 1'b1;
                        w_state_nxt = S_MUL;
                    end else begin
                        w_wr_single = w_legal;
                        w_state_nxt = S_DONE;
                    end
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_MUL: begin
                if (r_cnt == c_cnt_last) begin
                    w_mul_last  = 1'b1;
                    w_state_nxt = S_DONE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_res    <= '0;
            r_flags  <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
        end else begin
            r_busy <= (w_state_nxt == S_MUL);
            r_done <= (w_state_nxt == S_DONE);
            if (w_wr_single) begin
                r_res   <= w_res;
                r_flags <= w_flags;
            end
            if (w_start_mul) begin
                r_acc    <= '0;
                r_mcand  <= {{WIDTH{1'b0}}, w_a};
                r_mplier <= w_opb;
                r_cnt    <= '0;
            end else if (r_state == S_MUL) begin
                r_acc    <= w_acc_nxt;
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
                r_cnt    <= r_cnt + 1'b1;
            end
            if (w_mul_last) begin
                r_res   <= w_prod_lo;
                r_flags <= {1'b0, (w_acc_nxt[2*WIDTH-1:WIDTH] != '0),
                            w_prod_lo[WIDTH-1], (w_prod_lo == '0)};
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_mc.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_mc
// Purpose  : Directed self-checking bench for alu_mc at WIDTH=16.
// Revision : 1.0
// ============================================================================
module tb_alu_mc;
    localparam int c_w = 16;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    alu_mc_if #(.WIDTH(c_w)) u_if ();

    wire  [c_w-1:0] w_data;
    logic           r_drv;
    logic [c_w-1:0] r_b;
    assign w_data = r_drv ? r_b : {c_w{1'bz}};

    alu_mc #(.WIDTH(c_w)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_if.slave),
        .data  (w_data)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, act, exp);
    endtask

    task automatic read_res(output logic [c_w-1:0] v);
        u_if.ealu = 1'b1;
        #1;
        v = w_data;
        u_if.ealu = 1'b0;
        #1;
    endtask

    // Returns at the falling edge in the cycle right after the accepting edge.
    task automatic issue(input logic [3:0] op, input logic [c_w-1:0] a, input logic [c_w-1:0] b);
        @(negedge clk);
        u_if.ialu   = 1'b1;
        u_if.op     = op;
        u_if.data_a = a;
        u_if.ealu   = 1'b0;
        r_b         = b;
        r_drv       = 1'b1;
        @(negedge clk);
        u_if.ialu = 1'b0;
        r_drv     = 1'b0;
    endtask

    task automatic single(input string tag, input logic [3:0] op, input logic [c_w-1:0] a,
                          input logic [c_w-1:0] b, input logic [c_w-1:0] er, input logic [3:0] ef);
        logic [c_w-1:0] v;
        issue(op, a, b);
        check({tag, "_done"}, {31'd0, u_if.done}, 32'd1);
        read_res(v);
        check({tag, "_res"}, {16'd0, v}, {16'd0, er});
        check({tag, "_flags"}, {28'd0, u_if.flags}, {28'd0, ef});
    endtask

    task automatic run_mul(input string tag, input logic [c_w-1:0] a, input logic [c_w-1:0] b,
                           input logic [c_w-1:0] prev, input logic [c_w-1:0] er, input logic [3:0] ef);
        logic [c_w-1:0] v;
        issue(4'd8, a, b);
        for (int k = 1; k <= 16; k++) begin
            check({tag, "_busy"}, {30'd0, u_if.busy, u_if.done}, 32'd2);
            if (k == 8) begin
                read_res(v);
                check({tag, "_hold"}, {16'd0, v}, {16'd0, prev});
            end
            // Strobes while busy must be ignored, including on the final MUL edge.
            if (k == 4 || k == 16) begin
                u_if.ialu   = 1'b1;
                u_if.op     = 4'd1;
                u_if.data_a = 16'hFFFF;
                r_b         = 16'h0001;
                r_drv       = 1'b1;
            end
            @(negedge clk);
            u_if.ialu = 1'b0;
            r_drv     = 1'b0;
        end
        check({tag, "_done"}, {30'd0, u_if.busy, u_if.done}, 32'd1);
        read_res(v);
        check({tag, "_res"}, {16'd0, v}, {16'd0, er});
        check({tag, "_flags"}, {28'd0, u_if.flags}, {28'd0, ef});
    endtask

    typedef struct {
        logic [3:0]     op;
        logic [c_w-1:0] a;
        logic [c_w-1:0] b;
        logic [c_w-1:0] r;
        logic [3:0]     f;
    } vec_t;

    // flags = {V,C,N,Z}
    vec_t vecs[17] = '{
        '{4'd1, 16'hFFFF, 16'h0001, 16'h0000, 4'b0101},
        '{4'd1, 16'h7FFF, 16'h0001, 16'h8000, 4'b1010},
        '{4'd2, 16'h8000, 16'h0001, 16'h7FFF, 4'b1000},
        '{4'd2, 16'h0001, 16'h0002, 16'hFFFF, 4'b0110},
        '{4'd2, 16'h0005, 16'h0005, 16'h0000, 4'b0001},
        '{4'd0, 16'h0001, 16'd16,   16'h0000, 4'b0101},
        '{4'd0, 16'h0001, 16'd17,   16'h0000, 4'b0001},
        '{4'd0, 16'h8001, 16'd1,    16'h0002, 4'b0100},
        '{4'd0, 16'h1234, 16'd0,    16'h1234, 4'b0000},
        '{4'd6, 16'h8000, 16'd15,   16'h0001, 4'b0000},
        '{4'd6, 16'h8000, 16'd16,   16'h0000, 4'b0001},
        '{4'd9, 16'h8000, 16'd20,   16'hFFFF, 4'b0010},
        '{4'd9, 16'h8000, 16'd3,    16'hF000, 4'b0010},
        '{4'd3, 16'hA5A5, 16'hFFFF, 16'h5A5A, 4'b0000},
        '{4'd4, 16'h00F0, 16'h0F00, 16'h0FF0, 4'b0000},
        '{4'd5, 16'hF0F0, 16'hFF00, 16'hF000, 4'b0010},
        '{4'd7, 16'hFFFF, 16'h1234, 16'h0000, 4'b0001}
    };

    initial begin
        logic [c_w-1:0] v;
        logic           seen_done;

        rst_n       = 1'b0;
        u_if.ialu   = 1'b0;
        u_if.op     = 4'd0;
        u_if.data_a = '0;
        u_if.ealu   = 1'b0;
        r_drv       = 1'b0;
        r_b         = '0;
        repeat (3) @(negedge clk);
        check("rst_busy_done", {30'd0, u_if.busy, u_if.done}, 32'd0);
        check("rst_flags", {28'd0, u_if.flags}, 32'd0);
        read_res(v);
        check("rst_bus", {16'd0, v}, 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 17; i++) single($sformatf("vec%0d", i), vecs[i].op, vecs[i].a,
                                            vecs[i].b, vecs[i].r, vecs[i].f);
        @(negedge clk);
        check("idle_done", {30'd0, u_if.busy, u_if.done}, 32'd0);

        // Back-to-back issue: second strobe accepted from DONE.
        u_if.ialu = 1'b1; u_if.op = 4'd1; u_if.data_a = 16'h0001; r_b = 16'h0002; r_drv = 1'b1;
        @(negedge clk);
        check("b2b_done1", {31'd0, u_if.done}, 32'd1);
        u_if.op = 4'd3; u_if.data_a = 16'h00FF; r_b = 16'h0F0F;
        @(negedge clk);
        u_if.ialu = 1'b0; r_drv = 1'b0;
        check("b2b_done2", {31'd0, u_if.done}, 32'd1);
        read_res(v);
        check("b2b_res", {16'd0, v}, {16'd0, 16'h0FF0});

        // Accumulator loopback.
        single("acc_seed", 4'd1, 16'h0002, 16'h0003, 16'h0005, 4'b0000);
        @(negedge clk);
        u_if.ialu = 1'b1; u_if.op = 4'd1; u_if.data_a = 16'h0003; u_if.ealu = 1'b1;
        @(negedge clk);
        u_if.ialu = 1'b0; u_if.ealu = 1'b0;
        check("acc_done", {31'd0, u_if.done}, 32'd1);
        read_res(v);
        check("acc_res", {16'd0, v}, 32'h0008);
        check("acc_float", {31'd0, (w_data === 16'h0008)}, 32'd0);

        run_mul("mul1", 16'h0123, 16'h0010, 16'h0008, 16'h1230, 4'b0000);
        run_mul("mul2", 16'h1000, 16'h0010, 16'h1230, 16'h0000, 4'b0101);
        @(negedge clk);
        check("mul_idle", {30'd0, u_if.busy, u_if.done}, 32'd0);

        // Reset on cycle 8 of a multiply.
        single("pre_rst", 4'd1, 16'h0001, 16'h0001, 16'h0002, 4'b0000);
        issue(4'd8, 16'h0123, 16'h0010);
        repeat (7) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("mulrst_busy", {30'd0, u_if.busy, u_if.done}, 32'd0);
        seen_done = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            seen_done = seen_done | u_if.done | u_if.busy;
        end
        check("mulrst_nodone", {31'd0, seen_done}, 32'd0);
        read_res(v);
        check("mulrst_res", {16'd0, v}, 32'd0);

        // Illegal opcodes leave res and flags untouched.
        single("ill_seed", 4'd2, 16'h0001, 16'h0002, 16'hFFFF, 4'b0110);
        single("ill12", 4'd12, 16'h1111, 16'h2222, 16'hFFFF, 4'b0110);
        single("ill15", 4'd15, 16'h0000, 16'h0000, 16'hFFFF, 4'b0110);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
`default_nettype wire
